// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Holds the FSM state encoding and the bit-counter width function.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder shared across all operand bits
// by the serial adder controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped LSB-first over WIDTH bits.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow flag.
import serial_adder_pkg::*;

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   sum_cat;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Widened concat keeps the shift legal when WIDTH is 1.
    assign sum_cat = {fa_sum, sum_sh};

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b;
                carry_q <= cin;
                cnt     <= '0;
            end else if (state_q == RUN) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                carry_q <= fa_carry;
                cnt     <= cnt + CW'(1);
                sum_sh  <= sum_cat[WIDTH:1];
            end
            if (last) begin
                sum  <= sum_cat[WIDTH:1];
                cout <= fa_carry;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // carry_q still holds the carry into the MSB on the last-bit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= carry_q ^ fa_carry;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table plus
// hand sequences for ignored start, back-to-back and mid-run reset.
module tb_serial_adder_ctrl;

    localparam int W = 8;

`ifdef SERIAL_ADDER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t         vecs[6];
    logic [W-1:0] prev;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge (cycle T); returns at the negedge of T+1.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks cycles T+1..T+W, returns at the negedge of T+W+1.
    task automatic check_run(input logic [W-1:0] hold);
        for (int k = 1; k <= W; k++) begin
            if (k > 1) @(negedge clk);
            chk("busy_run", 32'(busy), 1);
            chk("done_run", 32'(done), 0);
            chk("sum_hold", 32'(sum), 32'(hold));
        end
        @(negedge clk);
    endtask

    task automatic check_done(input logic [W-1:0] es, input logic ec,
                              input logic eo);
        chk("done_pulse", 32'(done), 1);
        chk("busy_done", 32'(busy), 0);
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        chk("ovf", 32'(ovf), 32'(eo & OVF_ON));
    endtask

    initial begin
        vecs[0] = '{a:8'h5A, b:8'h33, cin:1'b0, sum:8'h8D, cout:1'b0, ovf:1'b1};
        vecs[1] = '{a:8'hFF, b:8'h01, cin:1'b0, sum:8'h00, cout:1'b1, ovf:1'b0};
        vecs[2] = '{a:8'h80, b:8'h80, cin:1'b0, sum:8'h00, cout:1'b1, ovf:1'b1};
        vecs[3] = '{a:8'h00, b:8'h00, cin:1'b1, sum:8'h01, cout:1'b0, ovf:1'b0};
        vecs[4] = '{a:8'h7F, b:8'h00, cin:1'b1, sum:8'h80, cout:1'b0, ovf:1'b1};
        vecs[5] = '{a:8'hC0, b:8'hC0, cin:1'b0, sum:8'h80, cout:1'b1, ovf:1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        prev = '0;
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin);
            check_run(prev);
            check_done(vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            prev = vecs[i].sum;
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 0);
            chk("sum_after", 32'(sum), 32'(prev));
        end

        // Start during RUN must be ignored.
        launch(8'h5A, 8'h33, 1'b0);
        for (int k = 1; k <= W; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 3) begin
                a     = 8'h11;
                b     = 8'h22;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk("ign_busy", 32'(busy), 1);
            chk("ign_done", 32'(done), 0);
        end
        @(negedge clk);
        start = 1'b0;
        check_done(8'h8D, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ign_no_done", 32'(done), 0);
            chk("ign_busy_low", 32'(busy), 0);
            chk("ign_sum", 32'(sum), 32'h8D);
        end

        // Start held in the DONE cycle chains straight into RUN.
        launch(8'h5A, 8'h33, 1'b0);
        check_run(8'h8D);
        check_done(8'h8D, 1'b0, 1'b1);
        launch(8'h01, 8'h02, 1'b0);
        check_run(8'h8D);
        check_done(8'h03, 1'b0, 1'b0);
        @(negedge clk);

        // Reset asserted mid-operation.
        launch(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_cout", 32'(cout), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle", 32'(busy), 0);
        end
        launch(8'h00, 8'h00, 1'b1);
        check_run(8'h00);
        check_done(8'h01, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
